// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - command codes, FSM encoding and default parameters for spi_master
package spi_master_pkg;

  localparam logic [2:0] SPI_CMD_XFER     = 3'd0;
  localparam logic [2:0] SPI_CMD_INIT     = 3'd1;
  localparam logic [2:0] SPI_CMD_SELECT   = 3'd2;
  localparam logic [2:0] SPI_CMD_DESELECT = 3'd3;
  localparam logic [2:0] SPI_CMD_SPEED    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_INIT,
    ST_FINISH
  } state_t;

  localparam int DEF_HALF_FAST   = 2;
  localparam int DEF_HALF_SLOW   = 125;
  localparam int DEF_INIT_CLOCKS = 80;
  localparam int DEF_CS_COUNT    = 1;
  localparam int DEF_TIMEOUT_CNT = 2500000;

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - restartable SCLK half-period tick generator with fast/slow divider
module spi_clkgen
  import spi_master_pkg::*;
#(
  parameter int HALF_FAST = DEF_HALF_FAST,
  parameter int HALF_SLOW = DEF_HALF_SLOW
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic slow,
  output logic tick,
  output logic sclk_en
);

  localparam int HMAX = (HALF_SLOW > HALF_FAST) ? HALF_SLOW : HALF_FAST;
  localparam int W    = $clog2(HMAX + 1);

  logic [W-1:0] cnt;
  logic [W-1:0] last;

  assign last = slow ? W'(HALF_SLOW - 1) : W'(HALF_FAST - 1);
  assign tick = (cnt == last);
  // SCLK moves one cycle ahead of the tick so MISO can be registered on the tick itself
  assign sclk_en = (cnt == last - W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-command SPI master (XFER/INIT/SELECT/DESELECT/SPEED); SPI_MASTER_TIMEOUT_EN adds idle timeout
module spi_master
  import spi_master_pkg::*;
#(
  parameter int HALF_FAST   = DEF_HALF_FAST,
  parameter int HALF_SLOW   = DEF_HALF_SLOW,
  parameter int INIT_CLOCKS = DEF_INIT_CLOCKS,
  parameter int CS_COUNT    = DEF_CS_COUNT,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int TIMEOUT_CNT = DEF_TIMEOUT_CNT
) (
  input  logic                clock,
  input  logic                reset,
  output logic [CS_COUNT-1:0] spi_cs,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd,
  input  logic [7:0]          cmd_data,
  input  logic [2:0]          cmd_sel,
  output logic [7:0]          rd_data,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  state_t      state, state_nxt;
  logic        accept, fast, last_half, tick, sclk_en;
  logic [15:0] half_cnt;
  logic [7:0]  tx, rx;

  assign accept    = cmd_valid && (state == ST_IDLE || state == ST_FINISH);
  assign busy      = (state == ST_XFER) || (state == ST_INIT);
  assign done      = (state == ST_FINISH);
  assign last_half = (state == ST_XFER) ? (half_cnt == 16'd15)
                                        : (half_cnt == 16'(2 * INIT_CLOCKS - 1));

  spi_clkgen #(.HALF_FAST(HALF_FAST), .HALF_SLOW(HALF_SLOW)) u_clkgen (
    .clock   (clock),
    .reset   (reset),
    .restart (accept),
    .slow    ((state == ST_INIT) || !fast),
    .tick    (tick),
    .sclk_en (sclk_en)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_FINISH: begin
        if (cmd_valid) begin
          case (cmd)
            SPI_CMD_XFER: state_nxt = ST_XFER;
            SPI_CMD_INIT: state_nxt = ST_INIT;
            default:      state_nxt = ST_FINISH;
          endcase
        end else if (state == ST_FINISH) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_XFER, ST_INIT: if (tick && last_half) state_nxt = ST_FINISH;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spi_cs   <= '1;
      spi_sclk <= 1'(CPOL);
      spi_mosi <= 1'b0;
      rd_data  <= '0;
      fast     <= 1'b0;
      half_cnt <= '0;
      tx       <= '0;
      rx       <= '0;
    end else if (accept) begin
      half_cnt <= '0;
      case (cmd)
        SPI_CMD_XFER: begin
          // CPHA=0 must present the MSB before the first leading edge
          tx <= (CPHA != 0) ? cmd_data : {cmd_data[6:0], 1'b0};
          if (CPHA == 0) spi_mosi <= cmd_data[7];
        end
        SPI_CMD_INIT: begin
          spi_cs   <= '1;
          spi_mosi <= 1'b1;
        end
        SPI_CMD_SELECT: begin
          for (int i = 0; i < CS_COUNT; i++) spi_cs[i] <= (int'(cmd_sel) != i);
        end
        SPI_CMD_DESELECT: spi_cs <= '1;
        SPI_CMD_SPEED:    fast <= cmd_data[0];
        default: ;
      endcase
    end else if (busy) begin
      if (sclk_en) spi_sclk <= ~spi_sclk;
      if (tick) begin
        half_cnt <= half_cnt + 16'd1;
        if (state == ST_XFER) begin
          if (half_cnt[0] != 1'(CPHA) && !last_half) begin
            spi_mosi <= tx[7];
            tx       <= tx << 1;
          end
          if (half_cnt[0] == 1'(CPHA)) rx <= {rx[6:0], spi_miso};
          if (last_half) rd_data <= (CPHA != 0) ? {rx[6:0], spi_miso} : rx;
        end else if (last_half) begin
          spi_mosi <= 1'b0;
        end
      end
    end
  end

`ifdef SPI_MASTER_TIMEOUT_EN
  logic [21:0] idle_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= 22'(TIMEOUT_CNT);
    end else if (accept) begin
      idle_cnt <= '0;
    end else if (state == ST_IDLE && idle_cnt != 22'(TIMEOUT_CNT)) begin
      idle_cnt <= idle_cnt + 22'd1;
    end
  end

  assign timeout = (idle_cnt == 22'(TIMEOUT_CNT));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed/random bench for spi_master in all four SPI modes against an SPI slave model
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int HF = 2, HS = 125, IC = 80, CSN = 4, TO = 60;
`ifdef SPI_MASTER_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           cmd_valid = 1'b0;
  logic [2:0]     cmd = '0, cmd_sel = '0;
  logic [7:0]     cmd_data = '0;
  logic [CSN-1:0] cs_o [4];
  logic           sclk_o [4], mosi_o [4], miso_i [4], busy_o [4], done_o [4], to_o [4];
  logic [7:0]     rd_o [4];
  logic [7:0]     slave_byte [4], s_in [4];
  int             s_edges [4];
  int             total = 0, bad = 0, t_acc = 0, lat = 0;
  bit             hold_ok;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int CP = m / 2, CH = m % 2;
    spi_master #(.HALF_FAST(HF), .HALF_SLOW(HS), .INIT_CLOCKS(IC), .CS_COUNT(CSN),
                 .CPOL(CP), .CPHA(CH), .TIMEOUT_CNT(TO)) dut (
      .clock(clk), .reset(rst), .spi_cs(cs_o[m]), .spi_sclk(sclk_o[m]), .spi_mosi(mosi_o[m]),
      .spi_miso(miso_i[m]), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_data(cmd_data),
      .cmd_sel(cmd_sel), .rd_data(rd_o[m]), .busy(busy_o[m]), .done(done_o[m]), .timeout(to_o[m])
    );

    // SPI slave: loads its reply when a command starts, then follows SCLK edges for its mode
    logic       pb = 1'b0;
    logic       ls = 1'(CP);
    logic [7:0] sh = '0;
    always @(sclk_o[m] or busy_o[m]) begin
      if (busy_o[m] === 1'b1 && !pb) begin
        sh = slave_byte[m];
        s_in[m] = '0;
        s_edges[m] = 0;
        if (CH == 0) miso_i[m] = sh[7];
      end else if (sclk_o[m] !== ls) begin
        if (sclk_o[m] !== 1'(CP)) begin
          s_edges[m]++;
          if (CH == 0) s_in[m] = {s_in[m][6:0], mosi_o[m]};
          else begin miso_i[m] = sh[7]; sh = sh << 1; end
        end else begin
          if (CH == 0) begin sh = sh << 1; miso_i[m] = sh[7]; end
          else s_in[m] = {s_in[m][6:0], mosi_o[m]};
        end
      end
      pb = (busy_o[m] === 1'b1);
      ls = sclk_o[m];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] d, input logic [2:0] s);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; cmd_data = d; cmd_sel = s;
    @(posedge clk);
    #1;
    t_acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit init_watch);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_watch && busy_o[0] === 1'b1)
        for (int m = 0; m < 4; m++)
          if (cs_o[m] !== '1 || mosi_o[m] !== 1'b1) hold_ok = 1'b0;
      if (done_o[0] === 1'b1) begin
        lat = cyc + 1 - t_acc;
        break;
      end
    end
  endtask

  task automatic check_xfer(input string tag, input int exp_lat, input logic [7:0] tx,
                            input logic [7:0] e [4]);
    chk({tag, " lat"}, lat, exp_lat);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("%s m%0d rd", tag, m), rd_o[m], e[m]);
      chk($sformatf("%s m%0d mosi", tag, m), s_in[m], tx);
      chk($sformatf("%s m%0d pulses", tag, m), s_edges[m], 8);
      chk($sformatf("%s m%0d sclk_idle", tag, m), sclk_o[m], m / 2);
      chk($sformatf("%s m%0d done", tag, m), done_o[m], 1);
    end
  endtask

  initial begin
    logic [7:0]     tx, txb;
    logic [7:0]     ea [4], eb [4], prev [4];
    logic [2:0]     tc [5], ts [5];
    logic [CSN-1:0] tcs [5];
    int             nd;

    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("reset m%0d cs", m), cs_o[m], 4'hF);
      chk($sformatf("reset m%0d sclk", m), sclk_o[m], m / 2);
      chk($sformatf("reset m%0d mosi", m), mosi_o[m], 0);
      chk($sformatf("reset m%0d rd", m), rd_o[m], 0);
      chk($sformatf("reset m%0d busy", m), busy_o[m], 0);
      chk($sformatf("reset m%0d done", m), done_o[m], 0);
      chk($sformatf("reset m%0d timeout", m), to_o[m], TO_EN);
    end
    rst = 1'b0;

    issue(SPI_CMD_SELECT, 8'h00, 3'd0);
    wait_done(5, 1'b0);
    chk("sel0 lat", lat, 1);
    chk("sel0 busy", busy_o[0], 0);
    for (int m = 0; m < 4; m++) chk($sformatf("sel0 m%0d cs", m), cs_o[m], 4'b1110);
    issue(SPI_CMD_SPEED, 8'h01, 3'd0);
    wait_done(5, 1'b0);
    chk("speed lat", lat, 1);

    for (int k = 0; k < 5; k++) begin
      tx = (k == 0) ? 8'h3C : 8'($urandom);
      for (int m = 0; m < 4; m++) begin
        ea[m] = (k == 0) ? 8'hA5 : 8'($urandom);
        slave_byte[m] = ea[m];
        prev[m] = rd_o[m];
      end
      issue(SPI_CMD_XFER, tx, 3'd0);
      chk("fast busy", busy_o[0], 1);
      repeat (12) @(negedge clk);
      for (int m = 0; m < 4; m++) chk($sformatf("partial m%0d rd", m), rd_o[m], prev[m]);
      wait_done(40, 1'b0);
      check_xfer("fast", 1 + 16 * HF, tx, ea);
      @(negedge clk);
      chk("done width", done_o[0], 0);
    end

    tx = 8'($urandom);
    txb = 8'($urandom);
    for (int m = 0; m < 4; m++) begin
      ea[m] = 8'($urandom);
      eb[m] = 8'($urandom);
      slave_byte[m] = ea[m];
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd = SPI_CMD_XFER; cmd_data = tx;
    @(posedge clk);
    #1;
    t_acc = cyc;
    for (int m = 0; m < 4; m++) slave_byte[m] = eb[m];
    @(negedge clk);
    cmd_data = txb;
    wait_done(40, 1'b0);
    check_xfer("held", 1 + 16 * HF, tx, ea);
    t_acc = cyc + 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("b2b busy", busy_o[0], 1);
    wait_done(40, 1'b0);
    check_xfer("b2b", 1 + 16 * HF, txb, eb);

    issue(SPI_CMD_SPEED, 8'h00, 3'd0);
    wait_done(5, 1'b0);
    chk("slowsel lat", lat, 1);
    tx = 8'($urandom);
    for (int m = 0; m < 4; m++) begin ea[m] = 8'($urandom); slave_byte[m] = ea[m]; end
    issue(SPI_CMD_XFER, tx, 3'd0);
    wait_done(2100, 1'b0);
    check_xfer("slow", 1 + 16 * HS, tx, ea);

    hold_ok = 1'b1;
    issue(SPI_CMD_INIT, 8'h00, 3'd0);
    wait_done(20100, 1'b1);
    chk("init lat", lat, 1 + 2 * IC * HS);
    chk("init cs_mosi_high", hold_ok, 1);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("init m%0d pulses", m), s_edges[m], IC);
      chk($sformatf("init m%0d cs", m), cs_o[m], 4'hF);
      chk($sformatf("init m%0d sclk", m), sclk_o[m], m / 2);
      chk($sformatf("init m%0d mosi_end", m), mosi_o[m], 0);
    end

    tc  = '{SPI_CMD_SELECT, SPI_CMD_SELECT, SPI_CMD_SELECT, 3'd6, SPI_CMD_DESELECT};
    ts  = '{3'd2, 3'd5, 3'd3, 3'd0, 3'd0};
    tcs = '{4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      issue(tc[i], 8'h00, ts[i]);
      wait_done(5, 1'b0);
      chk($sformatf("cs%0d lat", i), lat, 1);
      chk($sformatf("cs%0d busy", i), busy_o[0], 0);
      for (int m = 0; m < 4; m++) chk($sformatf("cs%0d m%0d cs", i, m), cs_o[m], tcs[i]);
    end

    issue(SPI_CMD_SPEED, 8'h01, 3'd0);
    wait_done(5, 1'b0);
    issue(SPI_CMD_SELECT, 8'h00, 3'd1);
    wait_done(5, 1'b0);
    issue(SPI_CMD_XFER, 8'($urandom), 3'd0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("midrst m%0d busy", m), busy_o[m], 0);
      chk($sformatf("midrst m%0d cs", m), cs_o[m], 4'hF);
      chk($sformatf("midrst m%0d rd", m), rd_o[m], 0);
      chk($sformatf("midrst m%0d done", m), done_o[m], 0);
      chk($sformatf("midrst m%0d sclk", m), sclk_o[m], m / 2);
      chk($sformatf("midrst m%0d mosi", m), mosi_o[m], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_o[0] === 1'b1) nd++;
    end
    chk("midrst no_done", nd, 0);
    chk("midrst idle busy", busy_o[0], 0);

`ifdef SPI_MASTER_TIMEOUT_EN
    issue(SPI_CMD_SELECT, 8'h00, 3'd0);
    chk("timeout cleared", to_o[0], 0);
    while (cyc < t_acc + TO) @(negedge clk);
    chk("timeout early", to_o[0], 0);
    @(negedge clk);
    for (int m = 0; m < 4; m++) chk($sformatf("timeout m%0d rise", m), to_o[m], 1);
    issue(SPI_CMD_DESELECT, 8'h00, 3'd0);
    chk("timeout reaccept", to_o[0], 0);
`else
    repeat (100) @(negedge clk);
    for (int m = 0; m < 4; m++) chk($sformatf("timeout m%0d off", m), to_o[m], 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Parametrised SPI master for SD-card and flash access, sitting between the CPU I/O port decoder and the board SPI pins. Executes one command at a time: a byte exchange, an 80-clock card wake-up sequence, chip-select control, or a speed change. Generalises the single-card controller with multiple chip selects, all four SPI modes, programmable fast/slow SCLK rates, and a completion pulse.

## Interface
- `HALF_FAST`, 2: fast SCLK half-period in `clock` cycles; minimum 2.
- `HALF_SLOW`, 125: slow SCLK half-period in cycles (100 kHz at 25 MHz).
- `INIT_CLOCKS`, 80: SCLK pulses issued by INIT.
- `CS_COUNT`, 1: number of chip-select lines (1..8).
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: sample on leading edge (0) or trailing edge (1).
- `TIMEOUT_CNT`, 2500000: idle-cycle timeout threshold.
- `clock` in 1: system clock, 25 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `spi_cs` out CS_COUNT: active-low chip selects.
- `spi_sclk` out 1: SPI clock.
- `spi_mosi` out 1: master data out, MSB first.
- `spi_miso` in 1: slave data in.
- `cmd_valid` in 1: command strobe, sampled when `busy`=0.
- `cmd` in 3: 0 XFER, 1 INIT, 2 SELECT, 3 DESELECT, 4 SPEED.
- `cmd_data` in 8: XFER byte to send; SPEED: bit0=1 selects fast.
- `cmd_sel` in 3: SELECT channel index.
- `rd_data` out 8: last received byte.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse when a command completes.
- `timeout` out 1: idle timeout reached.

## Operation
- Idle: `busy`=0 and `cmd_valid`=1 accepts the command. `cmd_valid` while `busy`=1 is ignored; there is no queue.
- States: IDLE, XFER, INIT, FINISH. SELECT, DESELECT, SPEED and codes 5..7 go IDLE→FINISH directly.
- XFER: 8 bits MSB first at the current half-period H.
  - CPHA=0: MOSI is valid before the first leading edge and changes on trailing edges.
  - CPHA=1: MOSI changes on leading edges.
  - MISO is registered one `clock` cycle after the sampling SCLK edge. This is why H≥2.
  - `rd_data` updates only at completion; a partial byte is never visible.
- INIT: all `spi_cs` high, MOSI high, INIT_CLOCKS full SCLK pulses at HALF_SLOW. Then SCLK returns to CPOL and MOSI to 0.
- SELECT: `spi_cs[cmd_sel]`=0 and all others 1. If `cmd_sel`≥CS_COUNT, all lines go high.
- DESELECT: all `spi_cs` high.
- SPEED: latches the rate used by subsequent XFERs. The reset value is slow.
- FINISH: `done`=1 and `busy`=0 in the same cycle, then IDLE.

## Timing
- Reset values: `spi_cs` all 1, `spi_sclk`=CPOL, `spi_mosi`=0, `rd_data`=0, `busy`=0, `done`=0, `timeout`=1 (timeout enabled) or 0 (disabled), speed=slow.
- Accept at edge T:
  - `busy`=1 from T+1.
  - XFER: `done` at T+1+16·H, with `rd_data` valid the same cycle.
  - INIT: `done` at T+1+2·INIT_CLOCKS·HALF_SLOW.
  - SELECT, DESELECT, SPEED, invalid codes: `done` at T+1 and `busy` stays 0.
- Back-to-back: a new command may be accepted in the `done` cycle. SCLK then has no gap beyond one idle half-period.
- Reset mid-command: all outputs take reset values immediately. The partial transfer is discarded and no `done` is issued.

## Configuration
- `SPI_MASTER_TIMEOUT_EN` defined:
  - A 22-bit saturating counter is cleared on every accepted command.
  - It increments each cycle while in IDLE and saturates at TIMEOUT_CNT.
  - `timeout` = (counter == TIMEOUT_CNT).
- Undefined: the counter is absent and `timeout` is tied 0.

## Structure
- Package `spi_master_pkg` holds:
  - the command code constants (`SPI_CMD_XFER` .. `SPI_CMD_SPEED`);
  - the state encoding;
  - default parameter constants.
- One sub-module, `spi_clkgen`:
  - a half-period tick generator with a selectable divider (HALF_FAST/HALF_SLOW);
  - restartable on command accept;
  - outputs a `tick` pulse per half-period.

## Test plan
- Reset, then mode 0, fast, slave returns 0xA5; SELECT 0, XFER 0x3C → MOSI bits 0,0,1,1,1,1,0,0; `rd_data`=0xA5; `done` at T+33; `spi_cs`=0b…10.
- Modes 1, 2, 3 with XFER 0x81 and loopback MISO=MOSI → `rd_data`=0x81; SCLK idles at CPOL; edges match CPHA.
- INIT with HALF_SLOW=125 → exactly 80 SCLK pulses; CS high and MOSI high throughout; `done` at T+1+20000.
- CS_COUNT=4: SELECT 2 → `spi_cs`=1011; SELECT 5 → 1111; DESELECT → 1111; each `done` at T+1.
- `cmd_valid` held during an XFER → ignored; assert `reset` at bit 4 → `busy`=0, `spi_cs` all 1, no `done`, `rd_data`=0.
- With SPI_MASTER_TIMEOUT_EN: idle 2500000 cycles after a command → `timeout` rises exactly then; next accept clears it. Without the macro, `timeout` stays 0.
